control_pipe: RTL and testbench

- Parametrised, registered successor to the combinational `control` decoder of the MIPS CPU. Sits between fetch and execute.
- Accepts 32-bit instructions over a valid/ready handshake and emits a registered, field-separated control bundle.
- Detects load-use hazards and sequences multi-cycle multiply stalls.
- Supports a pipeline flush for taken branches and jumps.

---
 rtl/control_pipe.sv | 131 +++++++++++++
 tb/tb_control_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: registered MIPS control decoder with valid/ready handshake, load-use stall and flush.
// Define CONTROL_MUL_EN to decode funct 24 as MUL and sequence its MUL_WAIT stall.
module control_pipe #(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int OPC_LW     = 54,
    parameter int OPC_SW     = 55,
    parameter int OPC_JMP    = 2,
    parameter int OPC_BR     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ex_ld_valid,
    input  logic [REG_AW-1:0]  ex_ld_rt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rt,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_wr,
    output logic               out_imm,
    output logic [1:0]         out_alu,
    output logic               out_mul,
    output logic               out_mux2,
    output logic               out_memwr,
    output logic               out_wb2,
    output logic               out_br,
    output logic               out_jmp,
    output logic               out_illegal,
    output logic               busy
);
    localparam int DW = 3 * REG_AW + 11;
    localparam logic [5:0] L_LW  = 6'(OPC_LW);
    localparam logic [5:0] L_SW  = 6'(OPC_SW);
    localparam logic [5:0] L_JMP = 6'(OPC_JMP);
    localparam logic [5:0] L_BR  = 6'(OPC_BR);

    logic [5:0]        w_op, w_fn;
    logic [REG_AW-1:0] w_f_rs, w_f_rt, w_f_rd, w_rs, w_rt, w_rd;
    logic              w_lw, w_sw, w_jmp, w_br, w_rtype, w_mulop, w_ralu, w_rok, w_use, w_legal;
    logic [1:0]        w_alu;
    logic [DW-1:0]     w_dec, r_dec;
    logic              w_hazard, w_run, w_accept, r_valid;
    logic              w_unused;

    assign w_op     = instr[31:26];
    assign w_fn     = instr[5:0];
    assign w_f_rs   = REG_AW'(instr[25:21]);
    assign w_f_rt   = REG_AW'(instr[20:16]);
    assign w_f_rd   = REG_AW'(instr[15:11]);
    assign w_unused = ^instr[10:6];

    assign w_lw    = w_op == L_LW;
    assign w_sw    = w_op == L_SW;
    assign w_jmp   = w_op == L_JMP;
    assign w_br    = w_op == L_BR;
    assign w_rtype = w_op == 6'd0;
`ifdef CONTROL_MUL_EN
    assign w_mulop = w_rtype && w_fn == 6'd24;
`else
    assign w_mulop = 1'b0;
`endif
    assign w_ralu  = w_fn == 6'd32 || w_fn == 6'd34 || w_fn == 6'd36 || w_fn == 6'd37;
    assign w_rok   = w_rtype && (w_ralu || w_mulop);
    assign w_use   = w_lw || w_sw || w_br || w_rok;
    assign w_legal = w_use || w_jmp;

    assign w_rs  = w_use ? w_f_rs : '0;
    assign w_rt  = w_use ? w_f_rt : '0;
    assign w_rd  = w_lw ? w_f_rt : w_sw ? w_f_rs : w_rok ? w_f_rd : '0;
    // funct 32/34/36/37 map onto add/sub/and/or through bits [2:0]
    assign w_alu = w_br ? 2'b01 : (w_rok && !w_mulop) ? {w_fn[2], w_fn[1] | w_fn[0]} : 2'b00;

    assign w_dec = {w_rs, w_rt, w_rd, w_lw || w_rok, w_lw || w_sw, w_alu, w_mulop,
                    w_lw || w_sw || w_jmp || w_rok, w_sw, w_rok, w_br, w_jmp, !w_legal};

    assign w_hazard = in_valid && ex_ld_valid && ex_ld_rt != '0 &&
                      (ex_ld_rt == w_f_rs || (ex_ld_rt == w_f_rt && (w_rtype || w_sw || w_br)));

    assign in_ready = (!r_valid || out_ready) && w_run && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef CONTROL_MUL_EN
    typedef enum logic {RUN, MUL_WAIT} state_t;
    state_t     r_state;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else if (r_state == MUL_WAIT) begin
            r_state <= r_cnt == 4'd1 ? RUN : MUL_WAIT;
            r_cnt   <= r_cnt - 4'd1;
        end else if (w_accept && w_mulop && MUL_CYCLES > 1) begin
            r_state <= MUL_WAIT;
            r_cnt   <= 4'(MUL_CYCLES - 1);
        end
    end

    assign w_run = r_state == RUN;
    assign busy  = r_state == MUL_WAIT;
`else
    localparam int UNUSED_MUL_CYCLES = MUL_CYCLES;
    assign w_run = 1'b1;
    assign busy  = 1'b0;
`endif

    assign out_valid = r_valid;
    assign {out_rs, out_rt, out_rd, out_wr, out_imm, out_alu, out_mul,
            out_mux2, out_memwr, out_wb2, out_br, out_jmp, out_illegal} = r_dec;
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed and randomized checks of control_pipe against a behavioural model.
module tb_control_pipe;
    localparam int MUL_CYCLES = 4;
`ifdef CONTROL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam logic [31:0] I_LW   = 32'hD822_0004;
    localparam logic [31:0] I_SW   = 32'hDC64_0004;
    localparam logic [31:0] I_JMP  = 32'h0800_0004;
    localparam logic [31:0] I_ADD  = 32'h00A6_3820;
    localparam logic [31:0] I_ADD0 = 32'h0006_3820;
    localparam logic [31:0] I_MUL  = 32'h00A6_3818;
    localparam logic [31:0] I_BAD  = 32'hFC22_1234;
    localparam logic [31:0] I_BADF = 32'h00A6_3821;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       wr, imm;
        logic [1:0] alu;
        logic       mul, mux2, memwr, wb2, br, jmp, ill;
    } bundle_t;

    logic clk = 1'b0, rst, in_valid, in_ready, ex_ld_valid, flush, out_valid, out_ready;
    logic [31:0] instr;
    logic [4:0]  ex_ld_rt, out_rs, out_rt, out_rd;
    logic        out_wr, out_imm, out_mul, out_mux2, out_memwr, out_wb2, out_br, out_jmp, out_illegal, busy;
    logic [1:0]  out_alu;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    control_pipe #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .ex_ld_valid(ex_ld_valid), .ex_ld_rt(ex_ld_rt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_wr(out_wr), .out_imm(out_imm), .out_alu(out_alu), .out_mul(out_mul), .out_mux2(out_mux2),
        .out_memwr(out_memwr), .out_wb2(out_wb2), .out_br(out_br), .out_jmp(out_jmp),
        .out_illegal(out_illegal), .busy(busy)
    );

    function automatic bundle_t obs();
        return {out_rs, out_rt, out_rd, out_wr, out_imm, out_alu, out_mul,
                out_mux2, out_memwr, out_wb2, out_br, out_jmp, out_illegal};
    endfunction

    function automatic bundle_t mk(int rs, int rt, int rd, bit wr, bit imm, int alu, bit mul,
                                   bit mux2, bit memwr, bit wb2, bit br, bit jmp, bit ill);
        bundle_t b;
        b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.wr = wr; b.imm = imm; b.alu = 2'(alu);
        b.mul = mul; b.mux2 = mux2; b.memwr = memwr; b.wb2 = wb2; b.br = br; b.jmp = jmp; b.ill = ill;
        return b;
    endfunction

    // Reference decoder written straight from the instruction-class table
    function automatic bundle_t ref_dec(logic [31:0] i);
        int fns [4] = '{32, 34, 36, 37};
        int op, fn, rs, rt, rd, k;
        op = int'(i[31:26]); fn = int'(i[5:0]);
        rs = int'(i[25:21]); rt = int'(i[20:16]); rd = int'(i[15:11]);
        k = -1;
        for (int j = 0; j < 4; j++) if (fn == fns[j]) k = j;
        if (op == 54) return mk(rs, rt, rt, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        if (op == 55) return mk(rs, rt, rs, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        if (op == 2)  return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        if (op == 4)  return mk(rs, rt, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        if (op == 0 && k >= 0) return mk(rs, rt, rd, 1, 0, k, 0, 1, 0, 1, 0, 0, 0);
        if (op == 0 && fn == 24 && MUL_EN) return mk(rs, rt, rd, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic bit ref_hazard(logic iv, logic lv, logic [4:0] lrt, logic [31:0] i);
        int op = int'(i[31:26]);
        bit uses_rt = op == 0 || op == 55 || op == 4;
        return iv && lv && lrt != 0 && (lrt == i[25:21] || (lrt == i[20:16] && uses_rt));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; instr = '0; ex_ld_valid = 0; ex_ld_rt = '0; flush = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = 1; instr = I_ADD; #1;
        tick();
        rst = 1; in_valid = 1; instr = I_LW;
        tick();
        rst = 0; in_valid = 0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (obs() !== bundle_t'(0)) begin errors++; $display("FAIL reset_bundle got=%h exp=0", obs()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_lw();
        bundle_t e = mk(1, 2, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        do_reset();
        in_valid = 1; instr = I_LW; out_ready = 1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 0; #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got=%b exp=1", out_valid); end
        checks++; if (obs() !== e) begin errors++; $display("FAIL lw_bundle got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        bundle_t es = mk(3, 4, 3, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        bundle_t ej = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        do_reset();
        out_ready = 1; in_valid = 1; instr = I_SW;
        tick();
        instr = I_JMP; #1;
        checks++; if (obs() !== es) begin errors++; $display("FAIL sw_bundle got=%h exp=%h", obs(), es); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 0; #1;
        checks++; if (obs() !== ej || out_valid !== 1'b1) begin errors++; $display("FAIL jmp_bundle got=%h/%b exp=%h/1", obs(), out_valid, ej); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_hold();
        bundle_t ea = mk(5, 6, 7, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        bundle_t el = mk(1, 2, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        do_reset();
        in_valid = 1; instr = I_ADD;
        tick();
        instr = I_LW;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || obs() !== ea) begin errors++; $display("FAIL hold_bundle cyc%0d got=%h/%b exp=%h/1", c, obs(), out_valid, ea); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready cyc%0d got=%b exp=0", c, in_ready); end
            tick();
        end
        out_ready = 1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 0; #1;
        checks++; if (obs() !== el) begin errors++; $display("FAIL release_next got=%h exp=%h", obs(), el); end
    endtask

    task automatic test_mul();
        do_reset();
        out_ready = 1; in_valid = 1; instr = I_MUL;
        tick();
        instr = I_ADD;
`ifdef CONTROL_MUL_EN
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (busy !== (k <= 3)) begin errors++; $display("FAIL mul_busy cyc%0d got=%b exp=%b", k, busy, k <= 3); end
            checks++; if (in_ready !== (k > 3)) begin errors++; $display("FAIL mul_ready cyc%0d got=%b exp=%b", k, in_ready, k > 3); end
            if (k == 1) begin
                checks++; if (obs() !== mk(5, 6, 7, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0)) begin errors++; $display("FAIL mul_bundle got=%h", obs()); end
            end
            tick();
        end
`else
        #1;
        checks++; if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin errors++; $display("FAIL mul_illegal got=%h", obs()); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mul_nostall got=%b/%b exp=0/1", busy, in_ready); end
        tick();
`endif
        in_valid = 0;
    endtask

    task automatic test_hazard();
        do_reset();
        out_ready = 1; ex_ld_valid = 1; ex_ld_rt = 5'd5; in_valid = 1; instr = I_ADD;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL hazard_stall cyc%0d got=%b/%b exp=0/0", c, in_ready, out_valid); end
            tick();
        end
        ex_ld_valid = 0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_clear got=%b exp=1", in_ready); end
        ex_ld_valid = 1; ex_ld_rt = 5'd0; instr = I_ADD0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_r0 got=%b exp=1", in_ready); end
        ex_ld_rt = 5'd2; instr = I_LW; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_lw_rt got=%b exp=1", in_ready); end
        ex_ld_rt = 5'd4; instr = I_SW; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_sw_rt got=%b exp=0", in_ready); end
        idle();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1; instr = I_ADD;
        tick();
        flush = 1; instr = I_LW; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        tick();
        flush = 0; in_valid = 0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
`ifdef CONTROL_MUL_EN
        out_ready = 1; in_valid = 1; instr = I_MUL;
        tick();
        instr = I_ADD; flush = 1; #1;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_mul_pre got=%b/%b exp=1/0", busy, in_ready); end
        tick();
        flush = 0; #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_mul_post got=%b/%b/%b exp=0/0/1", busy, out_valid, in_ready); end
        tick();
`endif
        idle();
    endtask

    task automatic test_illegal();
        bundle_t e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        out_ready = 1; in_valid = 1; instr = I_BAD;
        tick();
        instr = I_BADF; #1;
        checks++; if (obs() !== e) begin errors++; $display("FAIL illegal_op got=%h exp=%h", obs(), e); end
        tick();
        in_valid = 0; #1;
        checks++; if (obs() !== e) begin errors++; $display("FAIL illegal_funct got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_random();
        int fns [6] = '{32, 34, 36, 37, 24, 33};
        bundle_t m_b;
        bit m_v, exp_rdy, acc;
        int m_wait, kind;
        logic [5:0] op;
        do_reset();
        m_b = '0; m_v = 0; m_wait = 0;
        for (int n = 0; n < 800; n++) begin
            kind = $urandom_range(0, 7);
            op = kind == 0 ? 6'd54 : kind == 1 ? 6'd55 : kind == 2 ? 6'd2 : kind == 3 ? 6'd4 :
                 kind <= 5 ? 6'd0 : 6'($urandom_range(5, 63));
            instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                     6'(fns[$urandom_range(0, 5)])};
            rst = $urandom_range(0, 49) == 0;
            flush = $urandom_range(0, 19) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            ex_ld_valid = $urandom_range(0, 2) == 0;
            ex_ld_rt = 5'($urandom_range(0, 7));
            #1;
            exp_rdy = (!m_v || out_ready) && m_wait == 0 && !ref_hazard(in_valid, ex_ld_valid, ex_ld_rt, instr) && !flush;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, in_ready, exp_rdy); end
            checks++; if (out_valid !== m_v) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, m_v); end
            checks++; if (obs() !== m_b) begin errors++; $display("FAIL rnd_bundle n=%0d got=%h exp=%h", n, obs(), m_b); end
            checks++; if (busy !== (m_wait > 0)) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, m_wait > 0); end
            acc = in_valid && exp_rdy;
            if (rst) begin m_v = 0; m_b = '0; end
            else if (flush) m_v = 0;
            else if (acc) begin m_v = 1; m_b = ref_dec(instr); end
            else if (out_ready) m_v = 0;
            if (rst || flush) m_wait = 0;
            else if (m_wait > 0) m_wait--;
            else if (acc && ref_dec(instr).mul && MUL_CYCLES > 1) m_wait = MUL_CYCLES - 1;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_lw();
        test_back_to_back();
        test_hold();
        test_mul();
        test_hazard();
        test_flush();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
